vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 cen_16  in  1  one-clk-wide 16 MHz phase-advance enable.
REQ-004 vid_en  in  1  video fetch enable, sampled at phase 0.
REQ-005 vid_addr  in  15  video word address [15:1], sampled at phase 0.
REQ-006 cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read; cpu_addr  in  16; cpu_wdata  in  8; all sampled with cpu_req at grant.
REQ-008 ram_rdata  in  8  RAM read data.
REQ-009 ram_addr  out  16; ram_we  out  1; ram_wdata  out  8; all registered RAM port drives.
REQ-010 cpu_rdata  out  8  latched CPU read data; cpu_ack  out  1  one-clk completion pulse; ready  out  1  CPU wait line, 0 = stall.
REQ-011 vid_data  out  16  fetched word {odd byte, even byte}; vid_valid  out  1  one-clk pulse; phase  out  4  slot phase.

Function
REQ-012 phase SHALL increment modulo 16 on each clk with cen_16=1 (15 -> 0); no change without cen_16.
REQ-013 All following "at phase N" events SHALL occur on a clk edge with cen_16=1 and phase==N before increment.
REQ-014 FSM states SHALL be IDLE, VLO, VHI, CPU; only the transitions below are legal.
REQ-015 At phase 0 with vid_en=1: ram_addr <= {vid_addr,0}, ram_we <= 0, IDLE -> VLO. With vid_en=0: stay IDLE, no video fetch, no vid_valid.
REQ-016 At phase 2 in VLO: vid_data[7:0] <= ram_rdata, ram_addr <= {vid_addr_latched,1}, VLO -> VHI.
REQ-017 At phase 4 in VHI: vid_data[15:8] <= ram_rdata, vid_valid = 1 for exactly that clk, VHI -> IDLE.
REQ-018 Flag served SHALL set on cpu_ack and clear on any clk where cpu_req=0.
REQ-019 At phase 8 in IDLE with cpu_req=1 and served=0: ram_addr <= cpu_addr, ram_we <= cpu_we, ram_wdata <= cpu_wdata, IDLE -> CPU; otherwise stay IDLE.
REQ-020 At phase 12 in CPU: if read, cpu_rdata <= ram_rdata; ram_we <= 0; cpu_ack = 1 for that clk; CPU -> IDLE.
REQ-021 ready SHALL be 0 exactly while cpu_req=1 and served=0 and cpu_ack=0; else 1.
REQ-022 Video slot (phases 0-7) SHALL always take priority; CPU access SHALL never start outside phase 8.
REQ-023 cpu_req dropped during CPU state: the access SHALL still complete and cpu_ack still pulse; served clears the next clk.
REQ-024 cpu_req held high after cpu_ack: no second grant until cpu_req has been 0 for at least one clk.
REQ-025 Worst-case grant latency: request rising just after phase-8 sample SHALL be acked at phase 12 of the following 16-phase slot (20 cen_16 ticks).
REQ-026 ram_we SHALL be 1 only in CPU state with cpu_we=1.
REQ-027 vid_addr changes after phase 0 SHALL not affect the odd-byte address in the same slot.

Reset
REQ-028 While reset=1 (asynchronously): phase=0, state IDLE, served=0, ram_addr=0, ram_we=0, ram_wdata=0, cpu_rdata=0, cpu_ack=0, vid_data=0, vid_valid=0, ready=1 (forced regardless of cpu_req).
REQ-029 Reset asserted mid-CPU-write SHALL drop ram_we to 0 immediately, with no cpu_ack; after release the first event SHALL be phase 0.

Verification
REQ-030 vid_en=1, vid_addr=0x1234, RAM returns 0xAA at 0x2468 and 0x55 at 0x2469 -> at phase 4, vid_valid pulse, vid_data=0x55AA.
REQ-031 cpu_req read, cpu_addr=0xC000 (RAM 0x3C), raised at phase 5 -> ready=0 until phase-12 edge, cpu_ack pulse, cpu_rdata=0x3C, ram_we never 1.
REQ-032 cpu_req write 0x7F to 0x4001, raised at phase 9 -> no grant this slot; ram_we=1 from next phase 8 to phase 12; ack at phase 12 of next slot.
REQ-033 cpu_req held high 3 slots after ack -> exactly one cpu_ack; drop for 1 clk, re-raise -> second grant at next phase 8.
REQ-034 Reset pulse at phase 10 during a write -> ram_we=0 and ready=1 same cycle, no cpu_ack, phase=0 after release.
REQ-035 vid_en=0 for a full slot -> no vid_valid, ram_addr unchanged through phases 0-7, CPU slot unaffected.

Source files
------------

// File: rtl/vram_arbiter.sv
// Video/CPU RAM slot arbiter: a 16-phase slot gives phases 0-7 to a two-byte video fetch
// and phase 8 to a single CPU access, which completes at phase 12.
module vram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cen_16,
    input  logic        vid_en,
    input  logic [14:0] vid_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        ready,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic [3:0]  phase
);

    typedef enum logic [1:0] {IDLE, VLO, VHI, CPU} state_t;

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [14:0] vaddr_q, vaddr_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic [15:0] vid_data_q, vid_data_d;
    logic        vid_valid_q, vid_valid_d;
    logic        served_q, served_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= 4'd0;
            vaddr_q     <= 15'd0;
            ram_addr_q  <= 16'd0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 8'd0;
            cpu_rdata_q <= 8'd0;
            cpu_ack_q   <= 1'b0;
            vid_data_q  <= 16'd0;
            vid_valid_q <= 1'b0;
            served_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            vaddr_q     <= vaddr_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            served_q    <= served_d;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        vaddr_d     = vaddr_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = ram_we_q;
        ram_wdata_d = ram_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        vid_data_d  = vid_data_q;
        vid_valid_d = 1'b0;
        // Holding cpu_req after an ack keeps served set, blocking a second grant.
        served_d    = cpu_req & (served_q | cpu_ack_q);

        if (cen_16) begin
            phase_d = phase_q + 4'd1;
            unique case (state_q)
                IDLE: begin
                    if (phase_q == 4'd0 && vid_en) begin
                        vaddr_d    = vid_addr;
                        ram_addr_d = {vid_addr, 1'b0};
                        ram_we_d   = 1'b0;
                        state_d    = VLO;
                    end else if (phase_q == 4'd8 && cpu_req && !served_q) begin
                        ram_addr_d  = cpu_addr;
                        ram_we_d    = cpu_we;
                        ram_wdata_d = cpu_wdata;
                        state_d     = CPU;
                    end
                end
                VLO: begin
                    if (phase_q == 4'd2) begin
                        vid_data_d[7:0] = ram_rdata;
                        ram_addr_d      = {vaddr_q, 1'b1};
                        state_d         = VHI;
                    end
                end
                VHI: begin
                    if (phase_q == 4'd4) begin
                        vid_data_d[15:8] = ram_rdata;
                        vid_valid_d      = 1'b1;
                        state_d          = IDLE;
                    end
                end
                CPU: begin
                    if (phase_q == 4'd12) begin
                        // ram_we_q still holds the granted cpu_we, so it marks a write.
                        if (!ram_we_q) begin
                            cpu_rdata_d = ram_rdata;
                        end
                        ram_we_d  = 1'b0;
                        cpu_ack_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            endcase
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign phase     = phase_q;
    assign ready     = reset | ~(cpu_req & ~served_q & ~cpu_ack_q);

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: a slot-level reference model plus a behavioural
// RAM predict every registered output each cycle; directed runs cover the worked examples.
module tb_vram_arbiter;

    logic        clk, reset, cen_16, vid_en, cpu_req, cpu_we;
    logic [14:0] vid_addr;
    logic [15:0] cpu_addr, ram_addr, vid_data;
    logic [7:0]  cpu_wdata, ram_rdata, ram_wdata, cpu_rdata;
    logic        ram_we, cpu_ack, ready, vid_valid;
    logic [3:0]  phase;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .cen_16(cen_16), .vid_en(vid_en), .vid_addr(vid_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .ready(ready), .vid_data(vid_data),
        .vid_valid(vid_valid), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: asynchronous read, write on the clock edge.
    logic [7:0] ram [0:65535];
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    // Reference model: slot events by phase number, tracked per cen_16 tick.
    logic [7:0]  mem_model [0:65535];
    int          m_phase, m_vstage;
    logic [14:0] m_vaddr;
    logic [15:0] m_ram_addr, m_vdata, m_job_addr;
    logic [7:0]  m_ram_wdata, m_cpu_rdata;
    bit          m_ram_we, m_ack, m_valid, m_served, m_busy, m_job_we;

    int n_vec = 0;
    int n_err = 0;
    bit cen_tog = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_vstage = 0; m_vaddr = '0; m_ram_addr = '0; m_vdata = '0;
        m_job_addr = '0; m_ram_wdata = '0; m_cpu_rdata = '0; m_ram_we = 0; m_ack = 0;
        m_valid = 0; m_served = 0; m_busy = 0; m_job_we = 0;
    endtask

    task automatic model_update(input bit cen, input bit ve, input logic [14:0] va,
                                input bit req, input bit we, input logic [15:0] ca,
                                input logic [7:0] wd);
        bit ack_n, val_n, served_n;
        ack_n = 0;
        val_n = 0;
        served_n = req && (m_served || m_ack);
        if (cen) begin
            case (m_phase)
                0: if (ve) begin
                    m_vaddr = va; m_ram_addr = {va, 1'b0}; m_ram_we = 0; m_vstage = 1;
                end
                2: if (m_vstage == 1) begin
                    m_vdata[7:0] = mem_model[m_ram_addr]; m_ram_addr = {m_vaddr, 1'b1}; m_vstage = 2;
                end
                4: if (m_vstage == 2) begin
                    m_vdata[15:8] = mem_model[m_ram_addr]; val_n = 1; m_vstage = 0;
                end
                8: if (req && !m_served) begin
                    m_busy = 1; m_job_we = we; m_job_addr = ca;
                    m_ram_addr = ca; m_ram_we = we; m_ram_wdata = wd;
                    if (we) mem_model[ca] = wd;
                end
                12: if (m_busy) begin
                    if (!m_job_we) m_cpu_rdata = mem_model[m_job_addr];
                    m_ram_we = 0; ack_n = 1; m_busy = 0;
                end
                default: ;
            endcase
            m_phase = (m_phase + 1) % 16;
        end
        m_served = served_n;
        m_ack = ack_n;
        m_valid = val_n;
    endtask

    task automatic check_regs();
        check("phase", 32'(phase), 32'(m_phase));
        check("ram_addr", 32'(ram_addr), 32'(m_ram_addr));
        check("ram_we", 32'(ram_we), 32'(m_ram_we));
        check("ram_wdata", 32'(ram_wdata), 32'(m_ram_wdata));
        check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
        check("cpu_ack", 32'(cpu_ack), 32'(m_ack));
        check("vid_valid", 32'(vid_valid), 32'(m_valid));
        check("vid_data", 32'(vid_data), 32'(m_vdata));
    endtask

    // One clock: check registered outputs, drive the next inputs, check ready, advance model.
    task automatic step(input bit cen, input bit ve, input logic [14:0] va, input bit req,
                        input bit we, input logic [15:0] ca, input logic [7:0] wd);
        @(negedge clk);
        check_regs();
        cen_16 = cen; vid_en = ve; vid_addr = va;
        cpu_req = req; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
        #1;
        check("ready", 32'(ready), 32'(!(req && !m_served && !m_ack)));
        model_update(cen, ve, va, req, we, ca, wd);
    endtask

    task automatic idle_until_phase(input int ph);
        for (int i = 0; i < 200; i++) begin
            if (m_phase == ph) break;
            cen_tog = ~cen_tog;
            step(cen_tog, 1'b1, 15'h1234, 1'b0, 1'b0, 16'h0, 8'h0);
        end
        if (m_phase != ph) check("phase_wait_timeout", 32'(m_phase), 32'(ph));
    endtask

    task automatic cpu_access(input bit we, input logic [15:0] ca, input logic [7:0] wd);
        int i;
        for (i = 0; i < 200; i++) begin
            cen_tog = ~cen_tog;
            step(cen_tog, 1'b1, 15'h1234, 1'b1, we, ca, wd);
            if (m_ack) break;
        end
        if (!m_ack) check("ack_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        bit r_req, r_we, hold_after;
        logic [15:0] r_addr;
        logic [7:0]  r_wd;
        int gap, hold_cnt;

        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            mem_model[i] = ram[i];
        end
        ram[16'h2468] = 8'hAA; mem_model[16'h2468] = 8'hAA;
        ram[16'h2469] = 8'h55; mem_model[16'h2469] = 8'h55;
        ram[16'hC000] = 8'h3C; mem_model[16'hC000] = 8'h3C;

        // Reset with cpu_req high: ready must still read 1.
        reset = 1'b1; cen_16 = 1'b0; vid_en = 1'b0; vid_addr = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        model_reset();
        #23;
        check_regs();
        check("reset_ready", 32'(ready), 32'(1));
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Video fetch of word 0x1234 -> bytes 0x2468/0x2469.
        for (int i = 0; i < 100; i++) begin
            cen_tog = ~cen_tog;
            step(cen_tog, 1'b1, 15'h1234, 1'b0, 1'b0, 16'h0, 8'h0);
            if (m_valid) break;
        end
        @(posedge clk); #1;
        check("vid_word_1234", 32'(vid_data), 32'h55AA);
        check("vid_valid_1234", 32'(vid_valid), 32'(1));

        // CPU read of 0xC000 raised at phase 5.
        idle_until_phase(5);
        cpu_access(1'b0, 16'hC000, 8'h00);
        @(posedge clk); #1;
        check("cpu_read_c000", 32'(cpu_rdata), 32'h3C);

        // CPU write 0x7F to 0x4001 raised at phase 9: served in the next slot.
        idle_until_phase(9);
        cpu_access(1'b1, 16'h4001, 8'h7F);
        @(posedge clk); #1;
        check("cpu_write_4001", 32'(ram[16'h4001]), 32'h7F);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 15'h1234, 1'b0, 1'b0, 16'h0, 8'h0);

        // Reset pulse at phase 10 in the middle of a CPU write.
        for (int i = 0; i < 200; i++) begin
            if (m_busy && m_job_we && m_phase == 10) break;
            cen_tog = ~cen_tog;
            step(cen_tog, 1'b1, 15'h0100, 1'b1, 1'b1, 16'h4002, 8'h5A);
        end
        @(posedge clk); #2;
        check("pre_reset_we", 32'(ram_we), 32'(1));
        reset = 1'b1;
        #1;
        check("rst_ram_we", 32'(ram_we), 32'(0));
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_ack", 32'(cpu_ack), 32'(0));
        check("rst_phase", 32'(phase), 32'(0));
        cen_16 = 1'b0; cpu_req = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Randomized traffic with a well-behaved CPU master.
        r_req = 0; r_we = 0; hold_after = 0; r_addr = '0; r_wd = '0; gap = 3; hold_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (r_req) begin
                if (m_ack) begin
                    if (hold_after) begin
                        hold_after = 0; hold_cnt = 40;
                    end else begin
                        r_req = 0; gap = $urandom_range(2, 12);
                    end
                end else if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) begin r_req = 0; gap = $urandom_range(2, 12); end
                end else if (m_busy && $urandom_range(0, 29) == 0) begin
                    r_req = 0; hold_after = 0; gap = $urandom_range(2, 8);
                end
            end else if (!m_busy && !m_ack) begin
                if (gap > 0) gap--;
                else begin
                    r_req = 1;
                    r_we = 1'($urandom);
                    r_addr = ($urandom_range(0, 1) == 1) ? 16'hC000 + 16'($urandom_range(0, 7))
                                                         : 16'($urandom);
                    r_wd = 8'($urandom);
                    hold_after = ($urandom_range(0, 3) == 0);
                end
            end
            step(1'($urandom), $urandom_range(0, 3) != 0, 15'($urandom),
                 r_req, r_we, r_addr, r_wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
